// File: rtl/spiker_result_collector.sv
// Multi-beat, multi-timestep capture of the spiking core output vector.
// Frames are built in a shadow buffer and committed atomically to result_o.
module spiker_result_collector #(
    parameter int WIDTH      = 32,
    parameter int N_REG      = 24,
    parameter int BEAT_WIDTH = 256,
    parameter int CNT_W      = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     clear_i,
    input  logic                     start_i,
    input  logic                     mode_i,
    input  logic [CNT_W-1:0]         n_steps_i,
    input  logic [BEAT_WIDTH-1:0]    beat_i,
    input  logic                     beat_valid_i,
    output logic                     beat_ready_o,
    output logic [N_REG*WIDTH-1:0]   result_o,
    output logic                     result_valid_o,
    input  logic                     ack_i,
    output logic                     busy_o,
    output logic                     overrun_o,
    output logic [CNT_W-1:0]         step_cnt_o
);

    localparam int FW      = N_REG * WIDTH;
    localparam int N_BEATS = FW / BEAT_WIDTH;
    localparam int BIDX_W  = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        COMMIT  = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_s;
    logic                mode_r;
    logic [CNT_W-1:0]    n_eff_r;
    logic [FW-1:0]       shadow_r;
    logic [BIDX_W-1:0]   beat_idx_r;
    logic [CNT_W-1:0]    step_cnt_r;
    logic [FW-1:0]       result_r;
    logic                result_valid_r;
    logic                overrun_r;
    logic                accept_s;
    logic                last_beat_s;
    logic                last_step_s;

    // Next-state decode and beat handshake qualifiers
    always_comb begin
        state_s     = state_r;
        accept_s    = (state_r == COLLECT) && beat_valid_i;
        last_beat_s = (beat_idx_r == BIDX_W'(N_BEATS - 1));
        last_step_s = ((step_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1}) == n_eff_r);
        if (clear_i) begin
            state_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start_i) begin
                        state_s = COLLECT;
                    end else begin
                        state_s = IDLE;
                    end
                end
                COLLECT: begin
                    if (accept_s && last_beat_s && last_step_s) begin
                        state_s = COMMIT;
                    end else begin
                        state_s = COLLECT;
                    end
                end
                COMMIT:  state_s = IDLE;
                default: state_s = IDLE;
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Frame datapath: shadow capture, counters and committed result
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mode_r         <= 1'b0;
            n_eff_r        <= {CNT_W{1'b0}};
            shadow_r       <= {FW{1'b0}};
            beat_idx_r     <= {BIDX_W{1'b0}};
            step_cnt_r     <= {CNT_W{1'b0}};
            result_r       <= {FW{1'b0}};
            result_valid_r <= 1'b0;
            overrun_r      <= 1'b0;
        end else if (clear_i) begin
            shadow_r       <= {FW{1'b0}};
            beat_idx_r     <= {BIDX_W{1'b0}};
            step_cnt_r     <= {CNT_W{1'b0}};
            result_r       <= {FW{1'b0}};
            result_valid_r <= 1'b0;
            overrun_r      <= 1'b0;
        end else begin
            if ((state_r == IDLE) && start_i) begin
                mode_r     <= mode_i;
                n_eff_r    <= (n_steps_i == {CNT_W{1'b0}}) ? {{(CNT_W-1){1'b0}}, 1'b1} : n_steps_i;
                shadow_r   <= {FW{1'b0}};
                beat_idx_r <= {BIDX_W{1'b0}};
                step_cnt_r <= {CNT_W{1'b0}};
            end
            if (accept_s) begin
                for (int k = 0; k < N_BEATS; k++) begin
                    if (beat_idx_r == BIDX_W'(k)) begin
                        if (mode_r) begin
                            shadow_r[k*BEAT_WIDTH +: BEAT_WIDTH] <= shadow_r[k*BEAT_WIDTH +: BEAT_WIDTH] | beat_i;
                        end else begin
                            shadow_r[k*BEAT_WIDTH +: BEAT_WIDTH] <= beat_i;
                        end
                    end
                end
                if (last_beat_s) begin
                    beat_idx_r <= {BIDX_W{1'b0}};
                    step_cnt_r <= step_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end else begin
                    beat_idx_r <= beat_idx_r + BIDX_W'(1);
                end
            end
            // A commit wins over a same-edge ack; the ack then consumed the old frame, so no overrun
            if (state_r == COMMIT) begin
                result_r       <= shadow_r;
                result_valid_r <= 1'b1;
                if (result_valid_r && !ack_i) begin
                    overrun_r <= 1'b1;
                end
            end else if (ack_i) begin
                result_valid_r <= 1'b0;
            end
        end
    end

    assign beat_ready_o   = (state_r == COLLECT);
    assign busy_o         = (state_r != IDLE);
    assign result_o       = result_r;
    assign result_valid_o = result_valid_r;
    assign overrun_o      = overrun_r;
    assign step_cnt_o     = step_cnt_r;

endmodule

// File: tb/tb_spiker_result_collector.sv
// Directed self-checking bench for spiker_result_collector (default parameters, 3 beats per step).
module tb_spiker_result_collector;

    localparam int FW = 768;
    localparam int BW = 256;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            clear = 1'b0;
    logic            start = 1'b0;
    logic            mode = 1'b0;
    logic [15:0]     n_steps = 16'd0;
    logic [BW-1:0]   beat = '0;
    logic            beat_valid = 1'b0;
    logic            beat_ready;
    logic [FW-1:0]   result;
    logic            result_valid;
    logic            ack = 1'b0;
    logic            busy;
    logic            overrun;
    logic [15:0]     step_cnt;

    int errors = 0;
    int checks = 0;

    logic [BW-1:0] va, vb, vc, vd, ve, vf, vg, vh, vi;
    logic [FW-1:0] exp_frame;

    spiker_result_collector dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .clear_i        (clear),
        .start_i        (start),
        .mode_i         (mode),
        .n_steps_i      (n_steps),
        .beat_i         (beat),
        .beat_valid_i   (beat_valid),
        .beat_ready_o   (beat_ready),
        .result_o       (result),
        .result_valid_o (result_valid),
        .ack_i          (ack),
        .busy_o         (busy),
        .overrun_o      (overrun),
        .step_cnt_o     (step_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input logic m, input logic [15:0] n);
        start = 1'b1; mode = m; n_steps = n;
        tick();
        start = 1'b0; mode = 1'b0; n_steps = 16'd0;
    endtask

    task automatic send_beat(input logic [BW-1:0] d, input int gap);
        int w;
        beat_valid = 1'b0;
        for (int g = 0; g < gap; g++) tick();
        beat = d; beat_valid = 1'b1;
        w = 0;
        while (!beat_ready && w < 20) begin tick(); w++; end
        checks++;
        if (w >= 20) begin errors++; $display("FAIL beat_timeout ready=%0b required=1", beat_ready); end
        tick();
        beat_valid = 1'b0; beat = '0;
    endtask

    task automatic pulse_ack();
        ack = 1'b1; tick(); ack = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (result !== '0) begin errors++; $display("FAIL rst_result got=%h required=0", result); end
        checks++; if ({result_valid, busy, overrun, beat_ready} !== 4'b0000) begin errors++;
            $display("FAIL rst_flags got=%b required=0000", {result_valid, busy, overrun, beat_ready}); end
        checks++; if (step_cnt !== 16'd0) begin errors++; $display("FAIL rst_step got=%0d required=0", step_cnt); end
    endtask

    task automatic test_snapshot_single();
        start_frame(1'b0, 16'd1);
        send_beat(va, 0); send_beat(vb, 0); send_beat(vc, 0);
        checks++; if ({busy, beat_ready, result_valid} !== 3'b100) begin errors++;
            $display("FAIL snap_commit_state got=%b required=100", {busy, beat_ready, result_valid}); end
        tick();
        exp_frame = {vc, vb, va};
        checks++; if (result !== exp_frame) begin errors++; $display("FAIL snap_result got=%h required=%h", result, exp_frame); end
        checks++; if ({result_valid, busy, overrun} !== 3'b100) begin errors++;
            $display("FAIL snap_flags got=%b required=100", {result_valid, busy, overrun}); end
        checks++; if (step_cnt !== 16'd1) begin errors++; $display("FAIL snap_step got=%0d required=1", step_cnt); end
        pulse_ack();
        checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL ack_clear got=%b required=0", result_valid); end
        checks++; if (result !== exp_frame) begin errors++; $display("FAIL ack_hold got=%h required=%h", result, exp_frame); end
    endtask

    task automatic test_accumulate();
        start_frame(1'b1, 16'd3);
        send_beat({{(BW-4){1'b0}}, 4'h1}, 0); send_beat('0, 0); send_beat('0, 0);
        checks++; if (step_cnt !== 16'd1) begin errors++; $display("FAIL acc_mid_step got=%0d required=1", step_cnt); end
        send_beat({{(BW-4){1'b0}}, 4'h2}, 0); send_beat('0, 0); send_beat('0, 0);
        send_beat({{(BW-4){1'b0}}, 4'h4}, 0); send_beat('0, 0); send_beat('0, 0);
        tick();
        exp_frame = {{(FW-4){1'b0}}, 4'h7};
        checks++; if (result !== exp_frame) begin errors++; $display("FAIL acc_result got=%h required=%h", result, exp_frame); end
        checks++; if (step_cnt !== 16'd3) begin errors++; $display("FAIL acc_step got=%0d required=3", step_cnt); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL acc_overrun got=%b required=0", overrun); end
        pulse_ack();
    endtask

    task automatic test_nsteps_zero();
        start_frame(1'b0, 16'd0);
        send_beat(vd, 0); send_beat(ve, 0); send_beat(vf, 0);
        tick();
        exp_frame = {vf, ve, vd};
        checks++; if (result !== exp_frame) begin errors++; $display("FAIL n0_result got=%h required=%h", result, exp_frame); end
        checks++; if ({result_valid, busy} !== 2'b10) begin errors++; $display("FAIL n0_flags got=%b required=10", {result_valid, busy}); end
        checks++; if (step_cnt !== 16'd1) begin errors++; $display("FAIL n0_step got=%0d required=1", step_cnt); end
        pulse_ack();
    endtask

    task automatic test_snapshot_overwrite();
        start_frame(1'b0, 16'd2);
        send_beat('1, 0); send_beat('1, 0); send_beat('1, 0);
        send_beat('0, 0); send_beat('0, 0); send_beat('0, 0);
        tick();
        checks++; if (result !== '0) begin errors++; $display("FAIL ovw_result got=%h required=0", result); end
        checks++; if (step_cnt !== 16'd2) begin errors++; $display("FAIL ovw_step got=%0d required=2", step_cnt); end
        checks++; if ({result_valid, overrun} !== 2'b10) begin errors++; $display("FAIL ovw_flags got=%b required=10", {result_valid, overrun}); end
        pulse_ack();
    endtask

    task automatic test_gaps();
        checks++; if (beat_ready !== 1'b0) begin errors++; $display("FAIL idle_ready got=%b required=0", beat_ready); end
        start_frame(1'b0, 16'd1);
        send_beat(vg, 2);
        // start with a different mode/length mid-frame must be ignored
        start = 1'b1; mode = 1'b1; n_steps = 16'd5; tick(); start = 1'b0; mode = 1'b0; n_steps = 16'd0;
        send_beat(vh, 1); send_beat(vi, 3);
        checks++; if ({busy, beat_ready} !== 2'b10) begin errors++; $display("FAIL gap_commit got=%b required=10", {busy, beat_ready}); end
        tick();
        exp_frame = {vi, vh, vg};
        checks++; if (result !== exp_frame) begin errors++; $display("FAIL gap_result got=%h required=%h", result, exp_frame); end
        checks++; if ({result_valid, busy, beat_ready} !== 3'b100) begin errors++;
            $display("FAIL gap_flags got=%b required=100", {result_valid, busy, beat_ready}); end
    endtask

    task automatic test_overrun();
        start_frame(1'b0, 16'd1);
        send_beat(va, 0); send_beat(vb, 0); send_beat(vc, 0);
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_early got=%b required=0", overrun); end
        tick();
        checks++; if ({result_valid, overrun} !== 2'b11) begin errors++; $display("FAIL ovr_set got=%b required=11", {result_valid, overrun}); end
        pulse_ack();
        checks++; if ({result_valid, overrun} !== 2'b01) begin errors++; $display("FAIL ovr_sticky got=%b required=01", {result_valid, overrun}); end
    endtask

    task automatic test_clear_mid();
        start_frame(1'b0, 16'd1);
        send_beat(vd, 0);
        beat = ve; beat_valid = 1'b1; clear = 1'b1; start = 1'b1;
        tick();
        clear = 1'b0; beat_valid = 1'b0; beat = '0; start = 1'b0;
        checks++; if ({busy, beat_ready, result_valid, overrun} !== 4'b0000) begin errors++;
            $display("FAIL clr_flags got=%b required=0000", {busy, beat_ready, result_valid, overrun}); end
        checks++; if (result !== '0) begin errors++; $display("FAIL clr_result got=%h required=0", result); end
        checks++; if (step_cnt !== 16'd0) begin errors++; $display("FAIL clr_step got=%0d required=0", step_cnt); end
    endtask

    task automatic test_restart();
        start_frame(1'b0, 16'd1);
        send_beat(vg, 0); send_beat(vh, 0); send_beat(vi, 0);
        tick();
        exp_frame = {vi, vh, vg};
        checks++; if (result !== exp_frame) begin errors++; $display("FAIL rst_frame got=%h required=%h", result, exp_frame); end
        checks++; if ({result_valid, overrun} !== 2'b10) begin errors++; $display("FAIL restart_flags got=%b required=10", {result_valid, overrun}); end
    endtask

    task automatic test_ack_on_commit();
        start_frame(1'b0, 16'd1);
        send_beat(vd, 0); send_beat(ve, 0); send_beat(vf, 0);
        pulse_ack();
        exp_frame = {vf, ve, vd};
        checks++; if ({result_valid, overrun} !== 2'b10) begin errors++; $display("FAIL ackc_flags got=%b required=10", {result_valid, overrun}); end
        checks++; if (result !== exp_frame) begin errors++; $display("FAIL ackc_result got=%h required=%h", result, exp_frame); end
        pulse_ack();
        checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL ackc_clear got=%b required=0", result_valid); end
    endtask

    initial begin
        va = {8{32'hA0A0_0001}}; vb = {8{32'hB1B1_0002}}; vc = {8{32'hC2C2_0003}};
        vd = {8{32'h1234_5678}}; ve = {8{32'h9ABC_DEF0}}; vf = {8{32'h0F0F_F0F0}};
        vg = {4{64'hDEAD_BEEF_0000_0011}}; vh = {4{64'h0102_0304_0506_0708}}; vi = {4{64'h5555_AAAA_3333_CCCC}};
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        test_reset();
        test_snapshot_single();
        test_accumulate();
        test_nsteps_zero();
        test_snapshot_overwrite();
        test_gaps();
        test_overrun();
        test_clear_mid();
        test_restart();
        test_ack_on_commit();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
